// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, zero-register constant and writeback source encoding
package mips_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_REG       = 0;
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback port bundle between pipeline/long-latency unit and the arbiter
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = mips_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::DEF_ADDR_WIDTH
);
    logic                  RegWriteW;
    logic [ADDR_WIDTH-1:0] WriteRegW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic                  LLValid;
    logic [ADDR_WIDTH-1:0] LLReg;
    logic [DATA_WIDTH-1:0] LLData;
    logic                  LLReady;
    logic [ADDR_WIDTH-1:0] QueryReg;
    logic                  QueryHit;
    logic                  RFWE;
    logic [ADDR_WIDTH-1:0] RFWA;
    logic [DATA_WIDTH-1:0] RFWD;
    logic                  StallReq;
    modport master (
        output RegWriteW, WriteRegW, ResultW, LLValid, LLReg, LLData, QueryReg,
        input  LLReady, QueryHit, RFWE, RFWA, RFWD, StallReq
    );
    modport slave (
        input  RegWriteW, WriteRegW, ResultW, LLValid, LLReg, LLData, QueryReg,
        output LLReady, QueryHit, RFWE, RFWA, RFWD, StallReq
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small circular buffer of pending long-latency results with per-entry address visibility
module wb_fifo #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_WIDTH-1:0]            din_addr,
    input  logic [DATA_WIDTH-1:0]            din_data,
    output logic                             full,
    output logic                             empty,
    output logic [CW-1:0]                    count,
    output logic [ADDR_WIDTH-1:0]            head_addr,
    output logic [DATA_WIDTH-1:0]            head_data,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
    output logic [DEPTH-1:0]                 entry_valid
);
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0]                 valid_q;
    logic [PW-1:0]                    rd, wr;
    logic [CW-1:0]                    cnt;
    logic                             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full        = cnt == CW'(DEPTH);
    assign empty       = cnt == '0;
    assign count       = cnt;
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign head_addr   = addr_q[rd];
    assign head_data   = data_q[rd];
    assign entry_addr  = addr_q;
    assign entry_valid = valid_q;

    // payload storage carries no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr] <= din_addr;
            data_q[wr] <= din_data;
        end
    end

    // pointers, occupancy and valid flags; reset flushes everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd      <= '0;
            wr      <= '0;
            cnt     <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) begin
                valid_q[wr] <= 1'b1;
                wr          <= nxt(wr);
            end
            if (do_pop) begin
                valid_q[rd] <= 1'b0;
                rd          <= nxt(rd);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline and a long-latency result queue
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                                  busy, push, pop, full, empty, hit;
    logic [CW-1:0]                         count;
    logic [ADDR_WIDTH-1:0]                 head_addr;
    logic [DATA_WIDTH-1:0]                 head_data;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic [SW-1:0]                         starve, starve_nxt;
    logic                                  stall;
    wb_src_e                               src;

    // a write to the zero register is no write at all, so it frees the port
    assign busy         = bus.RegWriteW && bus.WriteRegW != ADDR_WIDTH'(ZERO_REG);
    assign bus.LLReady  = !rst && !full;
    assign push         = bus.LLValid && bus.LLReady && bus.LLReg != ADDR_WIDTH'(ZERO_REG);
    assign pop          = src == SRC_FIFO;
    assign bus.RFWE     = src != SRC_NONE;
    assign bus.RFWA     = (src == SRC_PIPE) ? bus.WriteRegW : (src == SRC_FIFO) ? head_addr : '0;
    assign bus.RFWD     = (src == SRC_PIPE) ? bus.ResultW   : (src == SRC_FIFO) ? head_data : '0;
    assign bus.QueryHit = hit && bus.QueryReg != ADDR_WIDTH'(ZERO_REG);
    assign bus.StallReq = stall;

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .din_addr    (bus.LLReg),
        .din_data    (bus.LLData),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // pipeline wins outright; the queue head only gets an idle port; nothing writes during reset
    always_comb begin
        src = rst ? SRC_NONE : busy ? SRC_PIPE : !empty ? SRC_FIFO : SRC_NONE;
    end

    // hazard lookup across every occupied queue slot
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (entry_valid[i] && entry_addr[i] == bus.QueryReg) hit = 1'b1;
    end

    // count cycles the queue is blocked by the pipeline, saturating at the limit
    always_comb begin
        starve_nxt = (pop || count == '0) ? '0
                   : (busy && starve != SW'(STARVE_LIMIT)) ? starve + SW'(1) : starve;
    end

    // stall request rises when starvation hits the limit and drops once the queue gets its write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
            stall  <= 1'b0;
        end else begin
            starve <= starve_nxt;
            stall  <= pop ? 1'b0 : (starve_nxt == SW'(STARVE_LIMIT)) ? 1'b1 : stall;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed table, reset corner cases and randomized checks against a queue model
module tb_wb_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          llv;
        logic [AW-1:0] llr;
        logic [DW-1:0] lld;
        logic [AW-1:0] qr;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic          e_rdy;
        logic          e_hit;
        logic          e_stall;
    } vec_t;

    ent_t q[$];
    int   starve = 0;
    bit   stall = 0;
    int   checks = 0;
    int   fails = 0;
    vec_t tbl[22];

    function automatic vec_t mk(int we, int wa, int wd, int llv, int llr, int lld, int qr,
                                int ewe, int ewa, int ewd, int rdy, int hit, int st);
        vec_t v;
        v.we = 1'(we);     v.wa = AW'(wa);     v.wd = DW'(wd);
        v.llv = 1'(llv);   v.llr = AW'(llr);   v.lld = DW'(lld);
        v.qr = AW'(qr);    v.e_we = 1'(ewe);   v.e_wa = AW'(ewa);
        v.e_wd = DW'(ewd); v.e_rdy = 1'(rdy);  v.e_hit = 1'(hit);
        v.e_stall = 1'(st);
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic llv, input logic [AW-1:0] llr, input logic [DW-1:0] lld,
                          input logic [AW-1:0] qr);
        bus.RegWriteW = we;  bus.WriteRegW = wa; bus.ResultW = wd;
        bus.LLValid   = llv; bus.LLReg     = llr; bus.LLData = lld;
        bus.QueryReg  = qr;
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0;
        stall  = 0;
    endtask

    // expected outputs derived from the queue contents and the priority rules
    task automatic check_model(input string tag);
        bit busy = bus.RegWriteW && bus.WriteRegW != 0;
        bit hit = 0;
        bit ewe = busy || q.size() > 0;
        logic [AW-1:0] ewa = busy ? bus.WriteRegW : (q.size() > 0) ? q[0].r : '0;
        logic [DW-1:0] ewd = busy ? bus.ResultW : (q.size() > 0) ? q[0].d : '0;
        foreach (q[i]) if (q[i].r == bus.QueryReg) hit = 1;
        hit = hit && bus.QueryReg != 0;
        chk({tag, ".rfwe"},  DW'(bus.RFWE), DW'(ewe));
        chk({tag, ".rfwa"},  DW'(bus.RFWA), DW'(ewa));
        chk({tag, ".rfwd"},  bus.RFWD, ewd);
        chk({tag, ".ready"}, DW'(bus.LLReady), DW'(q.size() < DEPTH));
        chk({tag, ".hit"},   DW'(bus.QueryHit), DW'(hit));
        chk({tag, ".stall"}, DW'(bus.StallReq), DW'(stall));
    endtask

    // what the next rising edge does to the pending-result queue and starvation state
    task automatic model_edge();
        bit busy = bus.RegWriteW && bus.WriteRegW != 0;
        int n = q.size();
        bit pop = !busy && n > 0;
        bit push = bus.LLValid && n < DEPTH && bus.LLReg != 0;
        if (pop || n == 0) starve = 0;
        else if (busy && starve < LIMIT) starve++;
        if (pop) stall = 0;
        else if (starve == LIMIT) stall = 1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{bus.LLReg, bus.LLData});
    endtask

    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic llv, input logic [AW-1:0] llr, input logic [DW-1:0] lld,
                         input logic [AW-1:0] qr, input string tag);
        @(negedge clk);
        set_in(we, wa, wd, llv, llr, lld, qr);
        #1;
        check_model(tag);
        model_edge();
    endtask

    initial begin
        //            we wa wd      llv llr lld    qr | we wa wd      rdy hit st
        tbl[0]  = mk(0, 0, 0,      0, 0,  0,      0,   0, 0, 0,      1, 0, 0);
        tbl[1]  = mk(0, 0, 0,      1, 8,  'h1234, 0,   0, 0, 0,      1, 0, 0);
        tbl[2]  = mk(0, 0, 0,      0, 0,  0,      8,   1, 8, 'h1234, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0,      0, 0,  0,      8,   0, 0, 0,      1, 0, 0);
        tbl[4]  = mk(1, 3, 'hAAAA, 1, 10, 100,    0,   1, 3, 'hAAAA, 1, 0, 0);
        tbl[5]  = mk(1, 3, 'hBBBB, 1, 11, 101,    10,  1, 3, 'hBBBB, 1, 1, 0);
        tbl[6]  = mk(1, 3, 'hCCCC, 1, 12, 102,    12,  1, 3, 'hCCCC, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0,      0, 0,  0,      11,  1, 10, 100,   0, 1, 0);
        tbl[8]  = mk(0, 0, 0,      0, 0,  0,      0,   1, 11, 101,   1, 0, 0);
        tbl[9]  = mk(0, 0, 0,      0, 0,  0,      0,   0, 0, 0,      1, 0, 0);
        tbl[10] = mk(0, 0, 0,      1, 5,  55,     0,   0, 0, 0,      1, 0, 0);
        tbl[11] = mk(1, 0, 'hDEAD, 0, 0,  0,      0,   1, 5, 55,     1, 0, 0);
        tbl[12] = mk(0, 0, 0,      0, 0,  0,      0,   0, 0, 0,      1, 0, 0);
        tbl[13] = mk(1, 2, 1,      1, 9,  99,     9,   1, 2, 1,      1, 0, 0);
        tbl[14] = mk(1, 2, 2,      0, 0,  0,      9,   1, 2, 2,      1, 1, 0);
        tbl[15] = mk(1, 2, 3,      0, 0,  0,      0,   1, 2, 3,      1, 0, 0);
        tbl[16] = mk(1, 2, 4,      0, 0,  0,      0,   1, 2, 4,      1, 0, 0);
        tbl[17] = mk(1, 2, 5,      0, 0,  0,      0,   1, 2, 5,      1, 0, 0);
        tbl[18] = mk(0, 0, 0,      0, 0,  0,      9,   1, 9, 99,     1, 1, 1);
        tbl[19] = mk(0, 0, 0,      0, 0,  0,      0,   0, 0, 0,      1, 0, 0);
        tbl[20] = mk(0, 0, 0,      1, 0,  77,     0,   0, 0, 0,      1, 0, 0);
        tbl[21] = mk(0, 0, 0,      0, 0,  0,      0,   0, 0, 0,      1, 0, 0);

        // reset with a busy pipeline: the write port must still be quiet
        set_in(1, 3, 'h55, 1, 4, 'h66, 0);
        #3;
        chk("reset.rfwe",  DW'(bus.RFWE), 0);
        chk("reset.ready", DW'(bus.LLReady), 0);
        chk("reset.stall", DW'(bus.StallReq), 0);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("release.ready", DW'(bus.LLReady), 1);

        for (int i = 0; i < 22; i++) begin
            string t = $sformatf("vec%0d", i);
            @(negedge clk);
            set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].llv, tbl[i].llr, tbl[i].lld, tbl[i].qr);
            #1;
            chk({t, ".rfwe"},  DW'(bus.RFWE), DW'(tbl[i].e_we));
            chk({t, ".rfwa"},  DW'(bus.RFWA), DW'(tbl[i].e_wa));
            chk({t, ".rfwd"},  bus.RFWD, tbl[i].e_wd);
            chk({t, ".ready"}, DW'(bus.LLReady), DW'(tbl[i].e_rdy));
            chk({t, ".hit"},   DW'(bus.QueryHit), DW'(tbl[i].e_hit));
            chk({t, ".stall"}, DW'(bus.StallReq), DW'(tbl[i].e_stall));
            model_edge();
        end

        // two pending entries, starvation built to a stall, then reset mid-cycle
        cycle(1, 7, 'h70, 1, 20, 'h200, 0, "pre0");
        cycle(1, 7, 'h71, 1, 21, 'h210, 0, "pre1");
        for (int i = 0; i < 4; i++) cycle(1, 7, DW'(i), 0, 0, 0, 21, "pre_busy");
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 20);
        #1;
        chk("pre_rst.stall", DW'(bus.StallReq), 1);
        chk("pre_rst.rfwa",  DW'(bus.RFWA), 20);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.rfwe",  DW'(bus.RFWE), 0);
        chk("mid_rst.ready", DW'(bus.LLReady), 0);
        chk("mid_rst.stall", DW'(bus.StallReq), 0);
        chk("mid_rst.hit",   DW'(bus.QueryHit), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("hold_rst.rfwe", DW'(bus.RFWE), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 20, "post_rst");

        // randomized traffic with small address ranges to hit zero-register and query collisions
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  AW'($urandom_range(0, 7)), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of register-file write data.
REQ-002 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-003 Parameter FIFO_DEPTH, default 2, number of pending long-latency results held.
REQ-004 Parameter STARVE_LIMIT, default 4, number of consecutive blocked cycles before a stall request.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 RegWriteW  in  1  pipeline writeback-stage write enable.
REQ-009 WriteRegW  in  ADDR_WIDTH  pipeline destination register.
REQ-010 ResultW  in  DATA_WIDTH  pipeline result (already muxed ALUOutW/ReadDataW).
REQ-011 LLValid  in  1  long-latency unit (mult/div) result valid.
REQ-012 LLReg  in  ADDR_WIDTH  long-latency destination register.
REQ-013 LLData  in  DATA_WIDTH  long-latency result.
REQ-014 LLReady  out  1  arbiter can accept a long-latency result.
REQ-015 QueryReg  in  ADDR_WIDTH  register address from the hazard unit.
REQ-016 QueryHit  out  1  QueryReg matches a pending FIFO entry.
REQ-017 RFWE / RFWA / RFWD  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port.
REQ-018 StallReq  out  1  registered request to the hazard unit to insert a writeback bubble.

Function
REQ-019 The pipeline port SHALL be busy when RegWriteW=1 and WriteRegW!=0; a pipeline write with WriteRegW=0 SHALL be treated as idle.
REQ-020 When the pipeline port is busy, RFWE/RFWA/RFWD SHALL equal 1/WriteRegW/ResultW in the same cycle (zero latency, highest priority).
REQ-021 When the pipeline port is idle and the FIFO is non-empty, the FIFO head SHALL drive RFWE=1/RFWA/RFWD and be popped at the clock edge.
REQ-022 When both are idle, RFWE=0, RFWA=0, RFWD=0.
REQ-023 LLReady SHALL be 1 iff FIFO count < FIFO_DEPTH, independent of a same-cycle pop.
REQ-024 A push SHALL occur on LLValid=1 and LLReady=1; with LLReg=0 the result is accepted but not stored.
REQ-025 Minimum push-to-write latency SHALL be 1 cycle; no combinational bypass from LL inputs to RFW*.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-027 QueryHit SHALL be combinational: 1 iff QueryReg!=0 and it equals LLReg of any valid FIFO entry.
REQ-028 Starve counter SHALL increment each cycle the FIFO is non-empty and the pipeline port is busy, saturating at STARVE_LIMIT.
REQ-029 Starve counter SHALL clear on any pop or when the FIFO is empty.
REQ-030 StallReq SHALL be set on the edge at which the counter reaches STARVE_LIMIT and cleared on the edge following the next pop.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-032 On rst=1, FIFO SHALL be flushed (count=0, pointers=0, entries invalid), pending results discarded, starve counter=0, StallReq=0.
REQ-033 During reset LLReady=0 and RFWE=0; LLReady SHALL return to 1 on the first cycle after rst deasserts.
REQ-034 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-035 DATA_WIDTH and ADDR_WIDTH defaults and the zero-register constant SHALL live in shared package mips_pkg.
REQ-036 FIFO storage and pointers SHALL be a sub-module wb_fifo with push/pop/full/empty/count and per-entry address outputs for QueryHit.
REQ-037 Arbitration, starvation counting and the StallReq register SHALL live in wb_port_arbiter.

Verification
REQ-038 Idle pipeline with LLValid=1, LLReg=8, LLData=0x1234 for 1 cycle -> next cycle RFWE=1, RFWA=8, RFWD=0x1234; count returns to 0.
REQ-039 Pipeline busy (WriteRegW=3) with 3 LL pushes -> two accepted, LLReady=0 on the third; writes then drain in order when RegWriteW=0.
REQ-040 FIFO holding one entry with pipeline busy for 4 cycles -> StallReq=1 after the 4th edge; with RegWriteW=0 the pop occurs, and StallReq=0 the following cycle.
REQ-041 RegWriteW=1, WriteRegW=0 with FIFO head LLReg=5 -> FIFO entry written that cycle (register-0 write ignored).
REQ-042 Pending entry LLReg=9, QueryReg=9 -> QueryHit=1; QueryReg=0 -> QueryHit=0.
REQ-043 rst pulsed mid-cycle with 2 entries pending -> RFWE=0, LLReady=0 and StallReq=0 immediately; no stale writes after release.
